// File: rtl/oneshot_scheduler.sv
// Four-channel one-shot pulse generator sharing a single timer.
// Falling trigger edges queue requests; a round-robin arbiter grants one channel at a time.
module oneshot_scheduler #(
  parameter int COUNTS0 = 1000,
  parameter int COUNTS1 = 1000,
  parameter int COUNTS2 = 1000,
  parameter int COUNTS3 = 1000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] TRG_N,
  input  logic [3:0] EN,
  output logic [3:0] OUT,
  output logic       BUSY,
  output logic [1:0] GNT
);

  localparam int MAX01 = (COUNTS0 > COUNTS1) ? COUNTS0 : COUNTS1;
  localparam int MAX23 = (COUNTS2 > COUNTS3) ? COUNTS2 : COUNTS3;
  localparam int MAXC  = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int CW    = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0] LAST0 = CW'(COUNTS0 - 1);
  localparam logic [CW-1:0] LAST1 = CW'(COUNTS1 - 1);
  localparam logic [CW-1:0] LAST2 = CW'(COUNTS2 - 1);
  localparam logic [CW-1:0] LAST3 = CW'(COUNTS3 - 1);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last_cnt;
  logic [3:0]    prev;
  logic [3:0]    pending;
  logic [3:0]    detect;
  logic [3:0]    grant_clr;
  logic [1:0]    winner;
  logic          found;
  logic          any_pend;
  logic          armed;

  // The first edge after reset only samples TRG_N, so a line held low
  // across reset release is not mistaken for a falling edge.
  assign detect   = prev & ~TRG_N & EN & {4{armed}};
  assign any_pend = |pending;

  always_comb begin
    case (GNT)
      2'd0:    last_cnt = LAST0;
      2'd1:    last_cnt = LAST1;
      2'd2:    last_cnt = LAST2;
      default: last_cnt = LAST3;
    endcase
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    winner = GNT;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && pending[2'(GNT + 2'(k))]) begin
        winner = 2'(GNT + 2'(k));
        found  = 1'b1;
      end
    end
  end

  assign grant_clr = (state == IDLE && any_pend) ? (4'b0001 << winner) : 4'b0000;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 4'b0000;
      prev    <= 4'b1111;
      armed   <= 1'b0;
      GNT     <= 2'd3;
      OUT     <= 4'b0000;
      BUSY    <= 1'b0;
    end else begin
      prev    <= TRG_N;
      armed   <= 1'b1;
      // A detect on the same edge as the grant wins over the clear.
      pending <= (pending & ~grant_clr) | detect;
      case (state)
        IDLE: begin
          if (any_pend) begin
            state <= RUN;
            GNT   <= winner;
            cnt   <= '0;
            OUT   <= 4'b0001 << winner;
            BUSY  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == last_cnt) begin
            state <= GAP;
            cnt   <= '0;
            OUT   <= 4'b0000;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          state <= IDLE;
          cnt   <= '0;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          OUT   <= 4'b0000;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oneshot_scheduler.sv
// Directed bench for oneshot_scheduler with pulse lengths 4,3,2,1.
// A negedge monitor logs every pulse (channel, length, start cycle) for checking.
module tb_oneshot_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] trg_n;
  logic [3:0] en;
  logic [3:0] out;
  logic       busy;
  logic [1:0] gnt;

  oneshot_scheduler #(
    .COUNTS0(4), .COUNTS1(3), .COUNTS2(2), .COUNTS3(1)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .TRG_N(trg_n),
    .EN   (en),
    .OUT  (out),
    .BUSY (busy),
    .GNT  (gnt)
  );

  typedef struct {
    int ch;
    int len;
    int start;
  } pulse_t;

  pulse_t q[$];
  int     cyc = 0;
  int     cur_len = 0;
  int     cur_ch = 0;
  int     cur_start = 0;
  int     busy_cnt = 0;
  int     onehot_err = 0;
  int     n_vec = 0;
  int     n_miss = 0;
  int     fall_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ($countones(out) > 1) onehot_err = onehot_err + 1;
    if (busy) busy_cnt = busy_cnt + 1;
    if (out != 4'b0000) begin
      if (cur_len == 0) begin
        cur_ch    = int'(out);
        cur_start = cyc;
      end
      cur_len = cur_len + 1;
    end else if (cur_len != 0) begin
      q.push_back('{ch: cur_ch, len: cur_len, start: cur_start});
      cur_len = 0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_pulse(input string tag, input int idx, input int ch, input int len);
    if (q.size() > idx) begin
      check({tag, "_ch"}, q[idx].ch, ch);
      check({tag, "_len"}, q[idx].len, len);
    end else begin
      check({tag, "_missing"}, q.size(), idx + 1);
    end
  endtask

  // Low cycles between pulse idx and idx+1 must be exactly 2.
  task automatic chk_gap(input string tag, input int idx);
    if (q.size() > idx + 1)
      check(tag, q[idx+1].start - (q[idx].start + q[idx].len), 2);
    else
      check({tag, "_missing"}, q.size(), idx + 2);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fall(input logic [3:0] m);
    trg_n = trg_n & ~m;
  endtask

  task automatic rise(input logic [3:0] m);
    trg_n = trg_n | m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n = 1'b0;
    trg_n = 4'hF;
    en    = 4'hF;
    tick(2);
    check("rst_out", int'(out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_gnt", int'(gnt), 3);
    rst_n = 1'b1;
    tick(2);

    // Single channel-0 shot
    q.delete();
    busy_cnt = 0;
    fall_cyc = cyc;
    fall(4'b0001);
    tick(12);
    chk_pulse("single", 0, 1, 4);
    check("single_count", q.size(), 1);
    check("single_busy", busy_cnt, 5);
    check("single_gnt", int'(gnt), 0);
    if (q.size() > 0) check("single_latency", q[0].start - fall_cyc, 2);
    rise(4'b0001);

    // All four at once after reset
    do_reset();
    q.delete();
    fall(4'b1111);
    tick(30);
    chk_pulse("sim0", 0, 1, 4);
    chk_pulse("sim1", 1, 2, 3);
    chk_pulse("sim2", 2, 4, 2);
    chk_pulse("sim3", 3, 8, 1);
    chk_gap("sim_gap01", 0);
    chk_gap("sim_gap12", 1);
    chk_gap("sim_gap23", 2);
    check("sim_count", q.size(), 4);

    // Round robin: ch1 running, ch0 and ch2 queued
    rise(4'b1111);
    tick(3);
    q.delete();
    fall(4'b0010);
    tick(2);
    fall(4'b0101);
    tick(25);
    chk_pulse("rr0", 0, 2, 3);
    chk_pulse("rr1", 1, 4, 2);
    chk_pulse("rr2", 2, 1, 4);
    check("rr_count", q.size(), 3);

    // Retrigger ch1 twice during its own run
    rise(4'b1111);
    tick(3);
    q.delete();
    fall(4'b0010); tick(1);
    rise(4'b0010); tick(1);
    fall(4'b0010); tick(1);
    rise(4'b0010); tick(1);
    fall(4'b0010);
    tick(25);
    chk_pulse("rtg0", 0, 2, 3);
    chk_pulse("rtg1", 1, 2, 3);
    chk_gap("rtg_gap", 0);
    check("rtg_count", q.size(), 2);

    // Masked channel and single-cycle channel
    rise(4'b1111);
    tick(3);
    en = 4'b1011;
    q.delete();
    fall(4'b0100);
    tick(10);
    check("mask_count", q.size(), 0);
    check("mask_busy", int'(busy), 0);
    fall(4'b1000);
    tick(10);
    chk_pulse("len1", 0, 8, 1);
    check("len1_count", q.size(), 1);

    // Dropping EN after the request keeps pending requests
    rise(4'b1111);
    tick(3);
    en = 4'hF;
    q.delete();
    fall(4'b1001);
    tick(1);
    en = 4'h0;
    tick(20);
    chk_pulse("endrop0", 0, 1, 4);
    chk_pulse("endrop1", 1, 8, 1);
    check("endrop_count", q.size(), 2);
    en = 4'hF;

    // Reset during a ch0 run with ch1 pending; triggers held low across release
    rise(4'b1111);
    tick(3);
    q.delete();
    fall(4'b0001);
    tick(2);
    fall(4'b0010);
    tick(1);
    check("prerst_out", int'(out), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out", int'(out), 0);
    check("midrst_busy", int'(busy), 0);
    tick(2);
    check("midrst_gnt", int'(gnt), 3);
    rst_n = 1'b1;
    q.delete();
    tick(15);
    check("postrst_count", q.size(), 0);
    check("postrst_busy", int'(busy), 0);
    rise(4'b0011);
    tick(2);
    fall(4'b0010);
    tick(10);
    chk_pulse("postrst_new", 0, 2, 3);
    check("postrst_new_count", q.size(), 1);

    check("onehot", onehot_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/oneshot_scheduler.md
ONESHOT_SCHEDULER -- requirements
Module: oneshot_scheduler

Interface
REQ-001 Parameter COUNTS0, default 1000, pulse length in CLK cycles for channel 0 (legal range >= 1).
REQ-002 Parameters COUNTS1 / COUNTS2 / COUNTS3, default 1000 each, pulse lengths for channels 1-3 (legal range >= 1).
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 TRG_N  input  4  per-channel trigger; a negative edge requests a pulse.
REQ-006 EN  input  4  per-channel enable; 0 drops that channel's new triggers.
REQ-007 OUT  output  4  one-hot pulse; bit i high while channel i owns the shared timer.
REQ-008 BUSY  output  1  high whenever state is not IDLE.
REQ-009 GNT  output  2  index of channel currently or most recently granted.

Function
REQ-010 One shared counter SHALL serve all four channels; at most one OUT bit high in any cycle.
REQ-011 Counter width SHALL be $clog2 of the largest COUNTSi (minimum 1 bit); no wrap occurs within a legal run.
REQ-012 Edge detect per channel: registered prev sample; detect_i = prev_i & ~TRG_N[i] & EN[i].
REQ-013 Edge E = rising edge at which detect_i is high; pending[i] SHALL be set at E.
REQ-014 pending[i] SHALL be cleared at the edge where channel i is granted; if detect_i is high at that same edge, set wins and pending[i] stays 1.
REQ-015 Repeated edges on a pending channel SHALL collapse into one request (no counting).
REQ-016 Edge on the running channel SHALL set pending and queue one rerun; the current pulse is neither extended nor restarted.
REQ-017 States: IDLE, RUN, GAP.
REQ-018 IDLE: if any pending bit is set, go to RUN, load winner into GNT, clear counter; else stay IDLE.
REQ-019 RUN: counter increments every cycle; when counter == COUNTS[GNT]-1, go to GAP.
REQ-020 GAP: counter cleared; go to IDLE next cycle.
REQ-021 OUT[GNT] SHALL be high exactly in RUN cycles: COUNTS[GNT] consecutive cycles per grant.
REQ-022 Minimum spacing between pulses SHALL be 2 cycles (GAP + IDLE), including back-to-back grants.
REQ-023 Arbitration SHALL be round-robin: search starts at GNT+1 mod 4 and takes the first pending channel.
REQ-024 Latency: pending already set before IDLE -> OUT high from the next edge; trigger arriving in IDLE at edge E -> OUT high from E+1.
REQ-025 Deasserting EN[i] SHALL NOT abort a run or clear an existing pending[i]; it only blocks new detects.
REQ-026 TRG_N held low SHALL NOT retrigger; a new high->low transition is required.

Reset
REQ-027 RST_N low SHALL asynchronously force: state IDLE, counter 0, pending 0, prev samples 1, GNT 3 (so channel 0 wins first), OUT 0, BUSY 0.
REQ-028 Reset mid-RUN SHALL drop OUT within the same cycle and discard all pending requests.
REQ-029 TRG_N held low across reset release SHALL NOT produce a pulse.

Verification (bench COUNTS0..3 = 4,3,2,1)
REQ-030 Single: EN=F, fall TRG_N[0] -> OUT=0001 for exactly 4 cycles; BUSY high 5 cycles (RUN+GAP); GNT=0.
REQ-031 Simultaneous: fall TRG_N[3:0] at the same edge after reset -> pulse order ch0(4), ch1(3), ch2(2), ch3(1), each separated by 2 low cycles.
REQ-032 Round-robin: GNT=1 done, pending ch0 and ch2 -> ch2 granted first, then ch0.
REQ-033 Retrigger: second fall on TRG_N[1] during its run -> run ends at 3 cycles; one further 3-cycle ch1 pulse follows; a third fall during the same run adds nothing.
REQ-034 Mask/length: EN[2]=0, fall TRG_N[2] -> no pulse ever; COUNTS3=1 -> OUT[3] high exactly 1 cycle.
REQ-035 Reset: assert RST_N low at cycle 2 of a ch0 run with ch1 pending -> OUT=0 immediately; after release, no pulses without new edges.
